nonce_sweeper: RTL and testbench

//  Mining sequencer wrapped around sha256_module: holds a 512-bit block template, writes a nonce into it,

---
 rtl/sweep_pkg.sv | 19 +
 rtl/hash_lt_cmp.sv | 18 +
 rtl/nonce_sweeper.sv | 224 ++++++++++++++++++++++
 tb/tb_nonce_sweeper.sv | 517 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// Shared types and widths for the nonce sweeper and its comparator.
package sweep_pkg;

    localparam int NONCE_W = 32;
    localparam int HASH_W  = 256;
    localparam int BLK_W   = 512;
    localparam int WORD_W  = 32;
    localparam int N_WORDS = BLK_W / WORD_W;

    // Sweep sequencer states: a nonce goes ISSUE -> WAIT -> CHECK, and DONE lasts one cycle
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } sweep_state_e;

endpackage

// File: rtl/hash_lt_cmp.sv
// Purely combinational unsigned a < b. The caller registers the operands,
// so this compare sits between two flops and is consumed in the CHECK state.
module hash_lt_cmp
    import sweep_pkg::*;
#(
    parameter int W = HASH_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         lt
);

    // Strict unsigned compare; equality is not a hit
    always_comb begin
        lt = (a < b);
    end

endmodule

// File: rtl/nonce_sweeper.sv
// Nonce sweeper: drives a SHA-256 core over a nonce range and stops at the
// first hash strictly below the target, or when the range is exhausted.
// Optional feature macro: SWEEP_WDOG_EN adds a WAIT-state watchdog and the
// timeout_err output; without it WAIT blocks until core_done.
module nonce_sweeper
    import sweep_pkg::*;
#(
    parameter int NONCE_WORD = 3
`ifdef SWEEP_WDOG_EN
    ,
    parameter int TIMEOUT    = 256
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [BLK_W-1:0]   tmpl_in,
    input  logic [HASH_W-1:0]  target_in,
    input  logic [NONCE_W-1:0] nonce_first,
    input  logic [NONCE_W-1:0] nonce_last,
    input  logic               cmd_start,
    input  logic               cmd_abort,
    output logic [BLK_W-1:0]   core_data_in,
    output logic               core_start,
    output logic               core_acc_rst,
    input  logic [HASH_W-1:0]  core_hash,
    input  logic               core_done,
    output logic               busy,
    output logic               found,
    output logic               exhausted,
    output logic [NONCE_W-1:0] found_nonce,
`ifdef SWEEP_WDOG_EN
    output logic               timeout_err,
`endif
    output logic [HASH_W-1:0]  found_hash
);

    sweep_state_e state_q, state_d;

    logic [BLK_W-1:0]   tmpl_q,        tmpl_d;
    logic [HASH_W-1:0]  target_q,      target_d;
    logic [NONCE_W-1:0] nonce_q,       nonce_d;
    logic [NONCE_W-1:0] last_q,        last_d;
    logic [HASH_W-1:0]  hash_q,        hash_d;
    logic               found_q,       found_d;
    logic               exhausted_q,   exhausted_d;
    logic [NONCE_W-1:0] found_nonce_q, found_nonce_d;
    logic [HASH_W-1:0]  found_hash_q,  found_hash_d;

    logic hash_lt;

`ifdef SWEEP_WDOG_EN
    localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic              timeout_err_q, timeout_err_d;
`endif

    // The registered hash is compared against the latched target; result used in CHECK
    hash_lt_cmp #(
        .W (HASH_W)
    ) u_cmp (
        .a  (hash_q),
        .b  (target_q),
        .lt (hash_lt)
    );

    // Next-state and datapath: every register holds unless the current state updates it
    always_comb begin
        state_d       = state_q;
        tmpl_d        = tmpl_q;
        target_d      = target_q;
        nonce_d       = nonce_q;
        last_d        = last_q;
        hash_d        = hash_q;
        found_d       = found_q;
        exhausted_d   = exhausted_q;
        found_nonce_d = found_nonce_q;
        found_hash_d  = found_hash_q;
        core_acc_rst  = 1'b0;
`ifdef SWEEP_WDOG_EN
        wdog_cnt_d    = wdog_cnt_q;
        timeout_err_d = timeout_err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (cmd_start && !cmd_abort) begin
                    tmpl_d      = tmpl_in;
                    target_d    = target_in;
                    nonce_d     = nonce_first;
                    last_d      = nonce_last;
                    found_d     = 1'b0;
                    exhausted_d = 1'b0;
`ifdef SWEEP_WDOG_EN
                    timeout_err_d = 1'b0;
`endif
                    state_d     = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                state_d = ST_WAIT;
`ifdef SWEEP_WDOG_EN
                wdog_cnt_d = '0;
`endif
            end

            ST_WAIT: begin
                if (core_done) begin
                    hash_d  = core_hash;
                    state_d = ST_CHECK;
                end
`ifdef SWEEP_WDOG_EN
                else if (wdog_cnt_q == WDOG_LAST) begin
                    core_acc_rst  = 1'b1;
                    timeout_err_d = 1'b1;
                    state_d       = ST_ISSUE;
                end else begin
                    wdog_cnt_d = wdog_cnt_q + 1'b1;
                end
`endif
            end

            ST_CHECK: begin
                if (hash_lt) begin
                    found_d       = 1'b1;
                    found_nonce_d = nonce_q;
                    found_hash_d  = hash_q;
                    state_d       = ST_DONE;
                end else if (nonce_q == last_q) begin
                    exhausted_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    nonce_d      = nonce_q + 1'b1;
                    core_acc_rst = 1'b1;
                    state_d      = ST_ISSUE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides whatever the state decided, but leaves the sticky results alone
        if (cmd_abort && (state_q != ST_IDLE)) begin
            state_d       = ST_IDLE;
            core_acc_rst  = 1'b1;
            nonce_d       = nonce_q;
            found_d       = found_q;
            exhausted_d   = exhausted_q;
            found_nonce_d = found_nonce_q;
            found_hash_d  = found_hash_q;
`ifdef SWEEP_WDOG_EN
            timeout_err_d = timeout_err_q;
`endif
        end
    end

    // Template mux: the current nonce replaces one word; stable while the core works on it
    always_comb begin
        core_data_in = tmpl_q;
        core_data_in[NONCE_WORD*WORD_W +: WORD_W] = nonce_q;
    end

    // Core handshake and status decoded straight from the state register, so no glitches
    always_comb begin
        core_start = (state_q == ST_ISSUE);
        busy       = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
    end

    assign found       = found_q;
    assign exhausted   = exhausted_q;
    assign found_nonce = found_nonce_q;
    assign found_hash  = found_hash_q;

    // Sequencer and datapath registers, all cleared by the asynchronous reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            tmpl_q        <= '0;
            target_q      <= '0;
            nonce_q       <= '0;
            last_q        <= '0;
            hash_q        <= '0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            found_nonce_q <= '0;
            found_hash_q  <= '0;
        end else begin
            state_q       <= state_d;
            tmpl_q        <= tmpl_d;
            target_q      <= target_d;
            nonce_q       <= nonce_d;
            last_q        <= last_d;
            hash_q        <= hash_d;
            found_q       <= found_d;
            exhausted_q   <= exhausted_d;
            found_nonce_q <= found_nonce_d;
            found_hash_q  <= found_hash_d;
        end
    end

`ifdef SWEEP_WDOG_EN
    assign timeout_err = timeout_err_q;

    // Watchdog counter and its sticky error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wdog_cnt_q    <= wdog_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end
`endif

endmodule

// File: tb/tb_nonce_sweeper.sv
// Directed testbench for nonce_sweeper with a fixed-latency stub core.
// Define SWEEP_WDOG_EN to also exercise the watchdog.
module tb_nonce_sweeper;

    localparam int NW       = 3;
    localparam int STUB_LAT = 20;

    logic         clk;
    logic         reset;
    logic [511:0] tmpl_in;
    logic [255:0] target_in;
    logic [31:0]  nonce_first;
    logic [31:0]  nonce_last;
    logic         cmd_start;
    logic         cmd_abort;
    logic [511:0] core_data_in;
    logic         core_start;
    logic         core_acc_rst;
    logic [255:0] core_hash;
    logic         core_done;
    logic         busy;
    logic         found;
    logic         exhausted;
    logic [31:0]  found_nonce;
    logic [255:0] found_hash;
`ifdef SWEEP_WDOG_EN
    logic         timeout_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [511:0] tmpl_pat;

    // stub core configuration
    logic [31:0]  hit_nonce;
    logic [255:0] hit_hash;
    logic [31:0]  eq_nonce;
    logic [255:0] eq_hash;
    logic         stub_enable;
    logic         stub_busy;
    int           stub_cnt;
    logic [31:0]  stub_nonce;

    // monitors
    int           start_cnt;
    int           acc_cnt;
    logic [31:0]  nonce_log[$];

    nonce_sweeper #(
        .NONCE_WORD (NW)
`ifdef SWEEP_WDOG_EN
        ,
        .TIMEOUT    (16)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tmpl_in      (tmpl_in),
        .target_in    (target_in),
        .nonce_first  (nonce_first),
        .nonce_last   (nonce_last),
        .cmd_start    (cmd_start),
        .cmd_abort    (cmd_abort),
        .core_data_in (core_data_in),
        .core_start   (core_start),
        .core_acc_rst (core_acc_rst),
        .core_hash    (core_hash),
        .core_done    (core_done),
        .busy         (busy),
        .found        (found),
        .exhausted    (exhausted),
        .found_nonce  (found_nonce),
`ifdef SWEEP_WDOG_EN
        .timeout_err  (timeout_err),
`endif
        .found_hash   (found_hash)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub hash: one chosen nonce hits, another equals the target, everything else is all-ones
    function automatic logic [255:0] stub_hash(input logic [31:0] n);
        if (n == hit_nonce) return hit_hash;
        if (n == eq_nonce)  return eq_hash;
        return '1;
    endfunction

    // Stub core: fixed latency after core_start, done held until the next start or acc reset
    always @(posedge clk) begin
        if (core_start) begin
            stub_busy  <= 1'b1;
            stub_cnt   <= STUB_LAT - 1;
            stub_nonce <= core_data_in[NW*32 +: 32];
            core_done  <= 1'b0;
        end else if (core_acc_rst) begin
            stub_busy <= 1'b0;
            core_done <= 1'b0;
        end else if (stub_busy && stub_enable) begin
            if (stub_cnt == 0) begin
                core_done <= 1'b1;
                core_hash <= stub_hash(stub_nonce);
                stub_busy <= 1'b0;
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    // Pulse monitors
    always @(posedge clk) begin
        if (core_start) begin
            start_cnt++;
            nonce_log.push_back(core_data_in[NW*32 +: 32]);
        end
        if (core_acc_rst) acc_cnt++;
    end

    // Hard stop in case something hangs outside the bounded waits
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    task automatic clear_monitors();
        start_cnt = 0;
        acc_cnt   = 0;
        nonce_log.delete();
    endtask

    task automatic start_sweep(input logic [31:0] first, input logic [31:0] last,
                               input logic [255:0] tgt);
        @(negedge clk);
        tmpl_in     = tmpl_pat;
        target_in   = tgt;
        nonce_first = first;
        nonce_last  = last;
        cmd_start   = 1'b1;
        @(negedge clk);
        cmd_start   = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_starts(input int n, input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (start_cnt >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        n_checks++;
        if (busy !== 1'b0 || core_start !== 1'b0 || core_acc_rst !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: busy=%b start=%b acc_rst=%b expected 0 0 0", busy, core_start, core_acc_rst);
        end
        n_checks++;
        if (found !== 1'b0 || exhausted !== 1'b0 || found_nonce !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_status: found=%b exhausted=%b nonce=%h expected 0 0 0", found, exhausted, found_nonce);
        end
        n_checks++;
        if (core_data_in !== 512'h0 || found_hash !== 256'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_data: data=%h hash=%h expected 0", core_data_in, found_hash);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_nonce();
        bit ok;
        logic [511:0] exp_data;
        clear_monitors();
        hit_nonce = 32'd5;
        hit_hash  = {32'h1234_5678, 32'h9ABC_DEF0, 192'h0};
        eq_nonce  = 32'hDEAD_BEEF;
        exp_data  = tmpl_pat;
        exp_data[NW*32 +: 32] = 32'd5;
        start_sweep(32'd5, 32'd5, '1);
        n_checks++;
        if (core_start !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL single_start_latency: core_start=%b expected 1", core_start);
        end
        n_checks++;
        if (core_data_in !== exp_data) begin
            n_fail++;
            $display("[TB] FAIL single_data_in: got %h expected %h", core_data_in, exp_data);
        end
        wait_idle(200, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL single_finish: busy still %b expected 0", busy);
        end
        n_checks++;
        if (found !== 1'b1 || exhausted !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL single_flags: found=%b exhausted=%b expected 1 0", found, exhausted);
        end
        n_checks++;
        if (found_nonce !== 32'd5) begin
            n_fail++;
            $display("[TB] FAIL single_nonce: got %h expected 00000005", found_nonce);
        end
        n_checks++;
        if (found_hash !== hit_hash) begin
            n_fail++;
            $display("[TB] FAIL single_hash: got %h expected %h", found_hash, hit_hash);
        end
        n_checks++;
        if (start_cnt !== 1) begin
            n_fail++;
            $display("[TB] FAIL single_starts: got %0d expected 1", start_cnt);
        end
    endtask

    task automatic test_sweep_hit();
        bit ok;
        logic [255:0] tgt;
        clear_monitors();
        tgt       = {32'h0000_0002, 224'h0};
        hit_nonce = 32'h10;
        hit_hash  = {32'h0000_0001, 224'h5};
        eq_nonce  = 32'h0F;
        eq_hash   = tgt;
        start_sweep(32'h0C, 32'h20, tgt);
        wait_idle(1000, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL hit_finish: busy still %b expected 0", busy);
        end
        n_checks++;
        if (start_cnt !== 5) begin
            n_fail++;
            $display("[TB] FAIL hit_starts: got %0d expected 5", start_cnt);
        end
        n_checks++;
        if (found !== 1'b1 || found_nonce !== 32'h10) begin
            n_fail++;
            $display("[TB] FAIL hit_nonce: found=%b nonce=%h expected 1 00000010", found, found_nonce);
        end
        n_checks++;
        if (found_hash !== hit_hash) begin
            n_fail++;
            $display("[TB] FAIL hit_hash: got %h expected %h", found_hash, hit_hash);
        end
        n_checks++;
        if (nonce_log.size() != 5 || nonce_log[0] !== 32'h0C || nonce_log[3] !== 32'h0F) begin
            n_fail++;
            $display("[TB] FAIL hit_order: size=%0d first=%h fourth=%h expected 5 0000000c 0000000f",
                     nonce_log.size(), nonce_log[0], nonce_log[3]);
        end
    endtask

    task automatic test_wrap_exhaust();
        bit ok;
        logic [31:0] exp_n[4];
        clear_monitors();
        exp_n[0]  = 32'hFFFF_FFFE;
        exp_n[1]  = 32'hFFFF_FFFF;
        exp_n[2]  = 32'h0000_0000;
        exp_n[3]  = 32'h0000_0001;
        hit_nonce = 32'h0;
        hit_hash  = 256'h0;
        eq_nonce  = 32'hDEAD_BEEF;
        start_sweep(32'hFFFF_FFFE, 32'h0000_0001, 256'h0);
        wait_idle(1000, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL wrap_finish: busy still %b expected 0", busy);
        end
        n_checks++;
        if (start_cnt !== 4) begin
            n_fail++;
            $display("[TB] FAIL wrap_starts: got %0d expected 4", start_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (nonce_log[i] !== exp_n[i]) begin
                n_fail++;
                $display("[TB] FAIL wrap_nonce_%0d: got %h expected %h", i, nonce_log[i], exp_n[i]);
            end
        end
        n_checks++;
        if (exhausted !== 1'b1 || found !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL wrap_flags: exhausted=%b found=%b expected 1 0", exhausted, found);
        end
        n_checks++;
        if (found_nonce !== 32'h10) begin
            n_fail++;
            $display("[TB] FAIL wrap_found_nonce_kept: got %h expected 00000010", found_nonce);
        end
    endtask

    task automatic test_abort();
        bit ok;
        int acc_before;
        clear_monitors();
        hit_nonce = 32'h300;
        hit_hash  = {32'h0000_0042, 224'h0};
        eq_nonce  = 32'hDEAD_BEEF;
        start_sweep(32'h100, 32'h1FF, 256'h0);
        wait_starts(3, 500, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL abort_reach_third: starts=%0d expected 3", start_cnt);
        end
        repeat (4) @(negedge clk);
        acc_before = acc_cnt;
        cmd_abort  = 1'b1;
        #1;
        n_checks++;
        if (core_acc_rst !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL abort_pulse: acc_rst=%b busy=%b expected 1 1", core_acc_rst, busy);
        end
        @(posedge clk);
        #1;
        cmd_abort = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || core_acc_rst !== 1'b0 || core_start !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abort_idle: busy=%b acc_rst=%b start=%b expected 0 0 0", busy, core_acc_rst, core_start);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (acc_cnt - acc_before !== 1 || start_cnt !== 3) begin
            n_fail++;
            $display("[TB] FAIL abort_pulse_count: acc=%0d starts=%0d expected 1 3", acc_cnt - acc_before, start_cnt);
        end
        n_checks++;
        if (found !== 1'b0 || exhausted !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abort_flags: found=%b exhausted=%b expected 0 0", found, exhausted);
        end
        clear_monitors();
        start_sweep(32'h300, 32'h300, '1);
        wait_idle(200, ok);
        n_checks++;
        if (!ok || nonce_log.size() != 1 || nonce_log[0] !== 32'h300) begin
            n_fail++;
            $display("[TB] FAIL abort_restart: ok=%0d size=%0d first=%h expected 1 1 00000300", ok, nonce_log.size(), nonce_log[0]);
        end
        n_checks++;
        if (found !== 1'b1 || found_nonce !== 32'h300) begin
            n_fail++;
            $display("[TB] FAIL abort_restart_found: found=%b nonce=%h expected 1 00000300", found, found_nonce);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        int starts_before;
        clear_monitors();
        hit_nonce = 32'hDEAD_BEEF;
        eq_nonce  = 32'hDEAD_BEEF;
        start_sweep(32'h40, 32'h50, 256'h0);
        wait_starts(1, 50, ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (core_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL areset_wait_done: core_done=%b expected 1", core_done);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (core_acc_rst !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL areset_in_check: acc_rst=%b busy=%b expected 1 1", core_acc_rst, busy);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || core_start !== 1'b0 || core_acc_rst !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL areset_ctrl: busy=%b start=%b acc_rst=%b expected 0 0 0", busy, core_start, core_acc_rst);
        end
        n_checks++;
        if (found_nonce !== 32'h0 || found_hash !== 256'h0 || core_data_in !== 512'h0 || found !== 1'b0 || exhausted !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL areset_data: nonce=%h found=%b exh=%b data_nonzero=%b expected 0 0 0 0",
                     found_nonce, found, exhausted, |core_data_in);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        starts_before = start_cnt;
        cmd_abort = 1'b1;
        cmd_start = 1'b1;
        tmpl_in   = tmpl_pat;
        @(negedge clk);
        cmd_abort = 1'b0;
        cmd_start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || core_start !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abort_start_idle: busy=%b start=%b expected 0 0", busy, core_start);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (start_cnt !== starts_before || core_data_in !== 512'h0) begin
            n_fail++;
            $display("[TB] FAIL abort_start_noop: starts=%0d data_nonzero=%b expected %0d 0", start_cnt, |core_data_in, starts_before);
        end
    endtask

`ifdef SWEEP_WDOG_EN
    task automatic test_watchdog();
        bit early_rst;
        clear_monitors();
        stub_enable = 1'b0;
        early_rst   = 1'b0;
        start_sweep(32'h77, 32'h80, 256'h0);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i < 16 && core_acc_rst === 1'b1) early_rst = 1'b1;
        end
        n_checks++;
        if (early_rst !== 1'b0 || core_acc_rst !== 1'b1 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL wdog_expire: early=%b acc_rst=%b terr=%b expected 0 1 0", early_rst, core_acc_rst, timeout_err);
        end
        @(negedge clk);
        n_checks++;
        if (core_start !== 1'b1 || timeout_err !== 1'b1 || core_data_in[NW*32 +: 32] !== 32'h77) begin
            n_fail++;
            $display("[TB] FAIL wdog_reissue: start=%b terr=%b nonce=%h expected 1 1 00000077",
                     core_start, timeout_err, core_data_in[NW*32 +: 32]);
        end
        cmd_abort = 1'b1;
        @(negedge clk);
        cmd_abort = 1'b0;
        stub_enable = 1'b1;
        start_sweep(32'h1, 32'h1, 256'h0);
        n_checks++;
        if (timeout_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL wdog_clear: terr=%b expected 0", timeout_err);
        end
        cmd_abort = 1'b1;
        @(negedge clk);
        cmd_abort = 1'b0;
    endtask
`endif

    initial begin
        reset       = 1'b0;
        cmd_start   = 1'b0;
        cmd_abort   = 1'b0;
        tmpl_in     = '0;
        target_in   = '0;
        nonce_first = '0;
        nonce_last  = '0;
        core_done   = 1'b0;
        core_hash   = '0;
        stub_busy   = 1'b0;
        stub_cnt    = 0;
        stub_nonce  = '0;
        stub_enable = 1'b1;
        hit_nonce   = 32'hDEAD_BEEF;
        hit_hash    = '0;
        eq_nonce    = 32'hDEAD_BEEF;
        eq_hash     = '0;
        start_cnt   = 0;
        acc_cnt     = 0;
        for (int k = 0; k < 16; k++) tmpl_pat[k*32 +: 32] = 32'hA5A5_0000 | k;

        $display("[TB] nonce_sweeper directed test starting");
        test_reset();
        test_single_nonce();
        test_sweep_hit();
        test_wrap_exhaust();
        test_abort();
        test_async_reset();
`ifdef SWEEP_WDOG_EN
        test_watchdog();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
